// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers MEM/WB results in order, drains one per cycle onto the
// register file write port, and forwards pending values to the two decode read ports.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     in_rdy,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_dst_addr,
    output logic [DW-1:0]            rf_dst,
    input  logic [AW-1:0]            fwd0_addr,
    input  logic [AW-1:0]            fwd1_addr,
    output logic                     fwd0_hit,
    output logic                     fwd1_hit,
    output logic [DW-1:0]            fwd0_data,
    output logic [DW-1:0]            fwd1_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic enq, store, deq;
    logic [PW-1:0] idx;

    // Outputs are masked by rst so nothing leaks out during the reset cycle itself.
    always_comb begin
        empty  = rst | (count_q == '0);
        full   = ~rst & (count_q == CW'(DEPTH));
        count  = rst ? '0 : count_q;
        in_rdy = ~full & ~rst;
        rf_we  = drain_en & ~empty;
        rf_dst_addr = empty ? '0 : mem_addr[head_q];
        rf_dst      = empty ? '0 : mem_data[head_q];
        enq   = in_vld & in_rdy;
        store = enq & (in_addr != '0);
        deq   = rf_we;
    end

    // Scan oldest to youngest so the last match seen is the youngest pending value.
    always_comb begin
        fwd0_hit  = 1'b0;
        fwd1_hit  = 1'b0;
        fwd0_data = '0;
        fwd1_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!rst && (CW'(i) < count_q)) begin
                if ((fwd0_addr != '0) && (mem_addr[idx] == fwd0_addr)) begin
                    fwd0_hit  = 1'b1;
                    fwd0_data = mem_data[idx];
                end
                if ((fwd1_addr != '0) && (mem_addr[idx] == fwd1_addr)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = mem_data[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (store) tail_q <= tail_q + 1'b1;
            if (deq)   head_q <= head_q + 1'b1;
            if (store && !deq)      count_q <= count_q + 1'b1;
            else if (!store && deq) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage is deliberately not reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_addr[tail_q] <= in_addr;
            mem_data[tail_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue with hand-computed expectations.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [3:0]  in_addr;
    logic [15:0] in_data;
    logic        in_rdy;
    logic        drain_en;
    logic        rf_we;
    logic [3:0]  rf_dst_addr;
    logic [15:0] rf_dst;
    logic [3:0]  fwd0_addr, fwd1_addr;
    logic        fwd0_hit, fwd1_hit;
    logic [15:0] fwd0_data, fwd1_data;
    logic [2:0]  count;
    logic        empty, full;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4), .AW(4), .DW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_rdy      (in_rdy),
        .drain_en    (drain_en),
        .rf_we       (rf_we),
        .rf_dst_addr (rf_dst_addr),
        .rf_dst      (rf_dst),
        .fwd0_addr   (fwd0_addr),
        .fwd1_addr   (fwd1_addr),
        .fwd0_hit    (fwd0_hit),
        .fwd1_hit    (fwd1_hit),
        .fwd0_data   (fwd0_data),
        .fwd1_data   (fwd1_data),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle inputs/outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] p5_rf_data [6];
    logic [3:0]  p5_rf_addr [6];
    logic        p5_full    [6];
    logic [2:0]  p5_count   [6];

    initial begin
        p5_rf_data = '{16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hC001, 16'hC002};
        p5_rf_addr = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
        p5_full    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        p5_count   = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};

        rst = 1'b1; in_vld = 1'b0; in_addr = '0; in_data = '0;
        drain_en = 1'b0; fwd0_addr = '0; fwd1_addr = '0;
        tick();
        tick();
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_rdy", 32'(in_rdy), 32'd1);

        // Single result through an empty queue.
        drain_en = 1'b1; in_vld = 1'b1; in_addr = 4'd3; in_data = 16'h1234;
        #1;
        check("t1_no_we_yet", 32'(rf_we), 32'd0);
        tick();
        in_vld = 1'b0; fwd0_addr = 4'd3;
        #1;
        check("t1_rf_we", 32'(rf_we), 32'd1);
        check("t1_rf_addr", 32'(rf_dst_addr), 32'd3);
        check("t1_rf_data", 32'(rf_dst), 32'h1234);
        check("t1_fwd_head_hit", 32'(fwd0_hit), 32'd1);
        tick();
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_we_off", 32'(rf_we), 32'd0);
        check("t1_rf_addr_zero", 32'(rf_dst_addr), 32'd0);

        // Fill while stalled, refuse a fifth, then drain in order.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_vld = 1'b1; in_addr = 4'(i); in_data = 16'hA000 + 16'(i);
            tick();
        end
        check("t2_full", 32'(full), 32'd1);
        check("t2_in_rdy", 32'(in_rdy), 32'd0);
        check("t2_count", 32'(count), 32'd4);
        in_addr = 4'd7; in_data = 16'hBEEF; fwd0_addr = 4'd2;
        tick();
        check("t2_count_after_5th", 32'(count), 32'd4);
        check("t2_fwd_data", 32'(fwd0_data), 32'hA002);
        check("t2_stall_head", 32'(rf_dst), 32'hA001);
        in_vld = 1'b0; drain_en = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain_we", 32'(rf_we), 32'd1);
            check("t2_drain_addr", 32'(rf_dst_addr), 32'(i));
            check("t2_drain_data", 32'(rf_dst), 32'hA000 + 32'(i));
            tick();
        end
        check("t2_empty", 32'(empty), 32'd1);

        // Youngest-wins forwarding, plus an R0 write that must vanish.
        drain_en = 1'b0;
        in_vld = 1'b1; in_addr = 4'd5; in_data = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        in_vld = 1'b0; fwd0_addr = 4'd5; fwd1_addr = 4'd6;
        #1;
        check("t3_fwd0_hit", 32'(fwd0_hit), 32'd1);
        check("t3_fwd0_data", 32'(fwd0_data), 32'h0022);
        check("t3_fwd1_hit", 32'(fwd1_hit), 32'd0);
        check("t3_fwd1_data", 32'(fwd1_data), 32'd0);
        in_vld = 1'b1; in_addr = 4'd0; in_data = 16'hFFFF; fwd0_addr = 4'd0;
        #1;
        check("t4_r0_rdy", 32'(in_rdy), 32'd1);
        check("t4_r0_fwd_hit", 32'(fwd0_hit), 32'd0);
        tick();
        in_vld = 1'b0;
        #1;
        check("t4_r0_count", 32'(count), 32'd2);
        check("t4_r0_no_we", 32'(rf_we), 32'd0);
        drain_en = 1'b1; fwd0_addr = 4'd5;
        #1;
        check("t4_drain_old", 32'(rf_dst), 32'h0011);
        check("t4_fwd_young", 32'(fwd0_data), 32'h0022);
        tick();
        check("t4_drain_new", 32'(rf_dst), 32'h0022);
        check("t4_fwd_head", 32'(fwd0_hit), 32'd1);
        tick();
        check("t4_empty", 32'(empty), 32'd1);

        // Sustained enqueue/dequeue starting from full; pointers wrap.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_vld = 1'b1; in_addr = 4'(i); in_data = 16'hB000 + 16'(i);
            tick();
        end
        drain_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_addr = 4'(8 + k); in_data = 16'hC000 + 16'(k);
            #1;
            check("t5_full", 32'(full), 32'(p5_full[k]));
            check("t5_count", 32'(count), 32'(p5_count[k]));
            check("t5_rf_addr", 32'(rf_dst_addr), 32'(p5_rf_addr[k]));
            check("t5_rf_data", 32'(rf_dst), 32'(p5_rf_data[k]));
            tick();
        end
        in_vld = 1'b0;
        #1;
        check("t5_left", 32'(count), 32'd3);
        check("t5_next_head", 32'(rf_dst), 32'hC003);

        // Reset with three entries pending.
        fwd0_addr = 4'd11; rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_we", 32'(rf_we), 32'd0);
        check("t6_rst_fwd", 32'(fwd0_hit), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_after_count", 32'(count), 32'd0);
        check("t6_after_we", 32'(rf_we), 32'd0);
        check("t6_after_fwd", 32'(fwd0_hit), 32'd0);
        tick();
        check("t6_no_stale_we", 32'(rf_we), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback write queue for the pipelined core; it is the producer side of the register file's single write port. It accepts completed results (destination address plus data) from the MEM/WB boundary over a valid/ready handshake and buffers up to DEPTH of them in order. It drains one entry per cycle onto the register file write port whenever that port is granted. It also supplies same-cycle forwarding of still-pending results to the two decode read addresses, so a read never returns stale data for a queued register.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- AW, 4, register address width
- DW, 16, data width

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_vld  in  1  result valid from MEM/WB
- in_addr  in  AW  result destination register
- in_data  in  DW  result value
- in_rdy  out  1  queue can accept this cycle
- drain_en  in  1  RF write port granted this cycle (low = port used by another writer)
- rf_we  out  1  write enable to RF write port
- rf_dst_addr  out  AW  write address to RF
- rf_dst  out  DW  write data to RF
- fwd0_addr, fwd1_addr  in  AW each  decode read addresses (p0/p1)
- fwd0_hit, fwd1_hit  out  1 each  pending entry matches
- fwd0_data, fwd1_data  out  DW each  youngest matching pending value
- count  out  $clog2(DEPTH)+1  occupied entries
- empty, full  out  1 each  count==0 / count==DEPTH

## Operation
- Circular buffer: head pointer, tail pointer, and count register, all sized from DEPTH. Pointers wrap modulo DEPTH.
- in_rdy = ~full & ~rst. An enqueue occurs when in_vld & in_rdy.
- Writes to R0 (in_addr==0): handshake completes (accepted), but nothing is stored and count is unchanged. R0 stays hardwired zero.
- Drain: rf_we = drain_en & ~empty. rf_dst_addr/rf_dst are driven from the head entry. When empty, they are driven 0.
- Dequeue occurs on the edge ending any cycle with rf_we=1. Head advances.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- When full, in_rdy=0 even if a dequeue happens that cycle. There is no bypass of a full queue.
- Entries drain strictly in arrival order. Two queued writes to the same register both reach the RF, oldest first.
- Forwarding (combinational on stored entries only; the in_* entry of the same cycle is not forwarded):
  - fwdN_hit=1 iff fwdN_addr≠0 and some occupied entry has matching address.
  - fwdN_data is the value of the youngest (closest to tail) matching entry, else 0.
  - The head entry being written this cycle still counts as a hit.
- The two forwarding ports are independent and may hit the same entry.

## Timing
- Reset (rst high at an edge): head=tail=count=0. Entry contents are not cleared.
- Outputs while and after reset: empty=1, full=0, count=0, rf_we=0, rf_dst_addr=0, rf_dst=0, fwd*_hit=0, fwd*_data=0.
- in_rdy=0 while rst is high. in_rdy=1 in the first cycle after reset.
- Reset mid-operation discards all pending entries. No RF write occurs in the cycle rst is high.
- Latency into an empty queue: accepted at edge N → rf_we high during cycle N+1 (if drain_en) → RF written that cycle.
- Throughput: one enqueue and one dequeue per cycle sustained.
- drain_en low stalls drain indefinitely with no loss. Head data holds stable while stalled.
- count, empty, full, and all rf_* outputs depend only on registered state and drain_en.

## Test plan
- Reset, then enqueue {R3,16'h1234} with drain_en=1 → next cycle rf_we=1, rf_dst_addr=3, rf_dst=16'h1234; following cycle empty=1.
- drain_en=0; enqueue R1..R4 with values 16'hA001..16'hA004 → full=1, in_rdy=0, count=4. A 5th in_vld is not accepted. Raise drain_en → RF writes occur in order R1..R4 on four consecutive cycles.
- drain_en=0; enqueue {R5,16'h0011} then {R5,16'h0022}; fwd0_addr=5 → fwd0_hit=1, fwd0_data=16'h0022. fwd1_addr=6 → fwd1_hit=0, fwd1_data=0.
- Enqueue {R0,16'hFFFF} → in_rdy=1, count unchanged, no rf_we. fwd0_addr=0 → hit=0.
- Full queue: hold drain_en=1 and in_vld=1 for 6 cycles → dequeue every cycle, enqueue only in cycles where full=0. Pointers wrap, and the data order is preserved.
- Queue holding 3 entries, assert rst for one cycle → count=0, rf_we=0 during and after. No stale RF writes follow.
